// File: rtl/demux16_router_pkg.sv
// demux16_router_pkg: shared constants for the 1-to-2 word router.
// Holds word width, channel select encodings and default sizing.
package demux16_router_pkg;

    // Default data word width in bits.
    localparam int WORD_WIDTH = 16;

    // Channel select encodings, sampled alongside inData.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Default sizing for the output FIFOs and delivered-word counters.
    localparam int DEFAULT_DEPTH     = 2;
    localparam int DEFAULT_CNT_WIDTH = 16;

    // Pointer width for a power-of-two FIFO; never below one bit.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width able to hold 0..depth inclusive.
    function automatic int occ_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/demux16_fifo.sv
// demux16_fifo: synchronous WIDTH x DEPTH FIFO used per output channel.
// Ports: clk, reset (sync, active-high), push_i/data_i (write side),
//        pop_i (read side), full_o, valid_o, head_o (0 when empty).
module demux16_fifo
    import demux16_router_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = ptr_bits(DEPTH);
    localparam int OW = occ_bits(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    rd_d;
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    wr_d;
    logic [OW-1:0]    occ_q;
    logic [OW-1:0]    occ_d;

    logic do_push;
    logic do_pop;

    assign full_o  = (occ_q == OW'(DEPTH));
    assign valid_o = (occ_q != '0);

    // Head is forced to zero while empty so stale storage never leaks.
    assign head_o = valid_o ? mem_q[rd_q] : '0;

    // A full FIFO refuses pushes even when it pops in the same cycle,
    // which keeps the upstream ready free of any downstream path.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        occ_d = occ_q;
        if (do_pop) begin
            rd_d = rd_q + PW'(1);
        end
        if (do_push) begin
            wr_d = wr_q + PW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            occ_q <= occ_d;
            if (do_push) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/demux16_router.sv
// demux16_router: steers one input word per cycle into FIFO A or B by select.
// Ports: clk, reset, inValid/inReady/inData/select (producer side),
//        outA*/outB* valid/ready/data (consumers), countA/countB delivered.
module demux16_router
    import demux16_router_pkg::*;
#(
    parameter int WIDTH     = WORD_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [WIDTH-1:0]     inData,
    input  logic                 select,
    output logic                 outAValid,
    input  logic                 outAReady,
    output logic [WIDTH-1:0]     outA,
    output logic                 outBValid,
    input  logic                 outBReady,
    output logic [WIDTH-1:0]     outB,
    output logic [CNT_WIDTH-1:0] countA,
    output logic [CNT_WIDTH-1:0] countB
);

    logic fullA;
    logic fullB;
    logic accept;
    logic pushA;
    logic pushB;
    logic popA;
    logic popB;

    logic [CNT_WIDTH-1:0] countA_q;
    logic [CNT_WIDTH-1:0] countA_d;
    logic [CNT_WIDTH-1:0] countB_q;
    logic [CNT_WIDTH-1:0] countB_d;

    // Ready looks only at the selected channel's registered full flag,
    // so a stalled channel never blocks words bound for the other one.
    assign inReady = !reset && ((select == SEL_A) ? !fullA : !fullB);

    assign accept = inValid && inReady;
    assign pushA  = accept && (select == SEL_A);
    assign pushB  = accept && (select == SEL_B);

    assign popA = outAValid && outAReady;
    assign popB = outBValid && outBReady;

    demux16_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk     (clk),
        .reset   (reset),
        .push_i  (pushA),
        .data_i  (inData),
        .pop_i   (popA),
        .full_o  (fullA),
        .valid_o (outAValid),
        .head_o  (outA)
    );

    demux16_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk     (clk),
        .reset   (reset),
        .push_i  (pushB),
        .data_i  (inData),
        .pop_i   (popB),
        .full_o  (fullB),
        .valid_o (outBValid),
        .head_o  (outB)
    );

    // Delivered-word counters wrap silently at their width.
    always_comb begin
        countA_d = countA_q;
        countB_d = countB_q;
        if (popA) begin
            countA_d = countA_q + CNT_WIDTH'(1);
        end
        if (popB) begin
            countB_d = countB_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            countA_q <= '0;
            countB_q <= '0;
        end else begin
            countA_q <= countA_d;
            countB_q <= countB_d;
        end
    end

    assign countA = countA_q;
    assign countB = countB_q;

endmodule

// File: tb/tb_demux16_router.sv
// tb_demux16_router: directed table plus hand sequences for demux16_router.
// Covers reset, steering, stalls, full-with-pop, mid-flight reset, wrap.
module tb_demux16_router;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [15:0] inData;
    logic        select;
    logic        outAValid;
    logic        outAReady;
    logic [15:0] outA;
    logic        outBValid;
    logic        outBReady;
    logic [15:0] outB;
    logic [15:0] countA;
    logic [15:0] countB;

    int n_total;
    int n_pass;

    demux16_router dut (
        .clk       (clk),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .inData    (inData),
        .select    (select),
        .outAValid (outAValid),
        .outAReady (outAReady),
        .outA      (outA),
        .outBValid (outBValid),
        .outBReady (outBReady),
        .outB      (outB),
        .countA    (countA),
        .countB    (countB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, passed=%0d total=%0d",
                 n_pass, n_total);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;
        logic        sel;
        logic [15:0] d;
        logic        ra;
        logic        rb;
        logic        e_rdy;
        logic        e_av;
        logic [15:0] e_a;
        logic        e_bv;
        logic [15:0] e_b;
        logic [15:0] e_ca;
        logic [15:0] e_cb;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(
        input logic iv, input logic sel, input logic [15:0] d,
        input logic ra, input logic rb, input logic e_rdy,
        input logic e_av, input logic [15:0] e_a,
        input logic e_bv, input logic [15:0] e_b,
        input logic [15:0] e_ca, input logic [15:0] e_cb);
        vec_t v;
        v.iv = iv; v.sel = sel; v.d = d; v.ra = ra; v.rb = rb;
        v.e_rdy = e_rdy; v.e_av = e_av; v.e_a = e_a;
        v.e_bv = e_bv; v.e_b = e_b; v.e_ca = e_ca; v.e_cb = e_cb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic sel,
                         input logic [15:0] d, input logic ra,
                         input logic rb);
        inValid   = iv;
        select    = sel;
        inData    = d;
        outAReady = ra;
        outBReady = rb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string nm, input logic v,
                         input logic [15:0] d);
        chk({nm, ".aValid"}, 32'(outAValid), 32'(v));
        chk({nm, ".a"}, 32'(outA), 32'(d));
    endtask

    task automatic chk_b(input string nm, input logic v,
                         input logic [15:0] d);
        chk({nm, ".bValid"}, 32'(outBValid), 32'(v));
        chk({nm, ".b"}, 32'(outB), 32'(d));
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

        // Row expectations describe state before the row's clock edge.
        vecs[0]  = mk(1, 0, 16'h1234, 1, 0, 1, 0, 16'h0, 0, 16'h0, 0, 0);
        vecs[1]  = mk(0, 0, 16'h0000, 1, 0, 1, 1, 16'h1234, 0, 16'h0, 0, 0);
        vecs[2]  = mk(0, 0, 16'h0000, 1, 0, 1, 0, 16'h0, 0, 16'h0, 1, 0);
        vecs[3]  = mk(1, 0, 16'h0000, 1, 1, 1, 0, 16'h0, 0, 16'h0, 1, 0);
        vecs[4]  = mk(1, 1, 16'h0001, 1, 1, 1, 1, 16'h0, 0, 16'h0, 1, 0);
        vecs[5]  = mk(1, 0, 16'h0002, 1, 1, 1, 0, 16'h0, 1, 16'h1, 2, 0);
        vecs[6]  = mk(1, 1, 16'h0003, 1, 1, 1, 1, 16'h2, 0, 16'h0, 2, 1);
        vecs[7]  = mk(1, 0, 16'h0004, 1, 1, 1, 0, 16'h0, 1, 16'h3, 3, 1);
        vecs[8]  = mk(1, 1, 16'h0005, 1, 1, 1, 1, 16'h4, 0, 16'h0, 3, 2);
        vecs[9]  = mk(1, 0, 16'h0006, 1, 1, 1, 0, 16'h0, 1, 16'h5, 4, 2);
        vecs[10] = mk(1, 1, 16'h0007, 1, 1, 1, 1, 16'h6, 0, 16'h0, 4, 3);
        vecs[11] = mk(0, 0, 16'h0000, 1, 1, 1, 0, 16'h0, 1, 16'h7, 5, 3);
        vecs[12] = mk(0, 0, 16'h0000, 1, 1, 1, 0, 16'h0, 0, 16'h0, 5, 4);

        repeat (2) tick();
        chk("rst.inReady", 32'(inReady), 32'd0);
        chk_a("rst", 1'b0, 16'h0);
        chk_b("rst", 1'b0, 16'h0);
        chk("rst.countA", 32'(countA), 32'd0);
        chk("rst.countB", 32'(countB), 32'd0);
        reset = 1'b0;
        #1;

        for (int i = 0; i < 13; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(vecs[i].iv, vecs[i].sel, vecs[i].d,
                  vecs[i].ra, vecs[i].rb);
            chk({nm, ".inReady"}, 32'(inReady), 32'(vecs[i].e_rdy));
            chk_a(nm, vecs[i].e_av, vecs[i].e_a);
            chk_b(nm, vecs[i].e_bv, vecs[i].e_b);
            chk({nm, ".countA"}, 32'(countA), 32'(vecs[i].e_ca));
            chk({nm, ".countB"}, 32'(countB), 32'(vecs[i].e_cb));
            tick();
        end

        // B stalls while full; A keeps flowing; B drains in order.
        drive(1, 1, 16'h9876, 1, 0);
        chk("stall.rdy0", 32'(inReady), 32'd1);
        tick();
        drive(1, 1, 16'hAAAA, 1, 0);
        chk("stall.rdy1", 32'(inReady), 32'd1);
        tick();
        drive(1, 1, 16'h5555, 1, 0);
        chk("stall.rdy2", 32'(inReady), 32'd0);
        chk_b("stall.full", 1'b1, 16'h9876);
        tick();
        drive(1, 0, 16'h0001, 1, 0);
        chk("stall.rdyA", 32'(inReady), 32'd1);
        tick();
        drive(0, 0, 16'h0, 1, 0);
        chk_a("stall.a", 1'b1, 16'h0001);
        chk_b("stall.hold", 1'b1, 16'h9876);
        tick();
        drive(0, 0, 16'h0, 1, 1);
        chk_a("stall.adone", 1'b0, 16'h0);
        chk("stall.countA", 32'(countA), 32'd6);
        chk_b("stall.b0", 1'b1, 16'h9876);
        tick();
        chk_b("stall.b1", 1'b1, 16'hAAAA);
        chk("stall.countB1", 32'(countB), 32'd5);
        tick();
        chk_b("stall.bdone", 1'b0, 16'h0);
        chk("stall.countB2", 32'(countB), 32'd6);

        // Full A with a pop in the same cycle still refuses the push.
        drive(1, 0, 16'h0011, 0, 0);
        tick();
        drive(1, 0, 16'h0022, 0, 0);
        tick();
        drive(1, 0, 16'h0033, 1, 0);
        chk("full.rdy", 32'(inReady), 32'd0);
        chk_a("full.head", 1'b1, 16'h0011);
        tick();
        drive(0, 0, 16'h0, 0, 0);
        chk("full.rdyNext", 32'(inReady), 32'd1);
        chk_a("full.next", 1'b1, 16'h0022);
        chk("full.countA", 32'(countA), 32'd7);
        drive(0, 0, 16'h0, 1, 0);
        tick();
        chk_a("full.empty", 1'b0, 16'h0);
        chk("full.countA2", 32'(countA), 32'd8);

        // Reset with words parked in B discards them.
        drive(1, 1, 16'h0077, 0, 0);
        tick();
        drive(1, 1, 16'h0088, 0, 0);
        tick();
        drive(0, 0, 16'h0, 0, 0);
        chk_b("mid.loaded", 1'b1, 16'h0077);
        reset = 1'b1;
        #1;
        chk("mid.rdyRst", 32'(inReady), 32'd0);
        tick();
        reset = 1'b0;
        drive(0, 0, 16'h0, 0, 1);
        chk_b("mid.cleared", 1'b0, 16'h0);
        chk("mid.countB", 32'(countB), 32'd0);
        chk("mid.countA", 32'(countA), 32'd0);
        tick();
        chk_b("mid.after", 1'b0, 16'h0);

        // Deliver 65535 words on A, then one more to wrap the counter.
        drive(1, 0, 16'h0, 1, 0);
        for (int i = 0; i < 65535; i++) begin
            inData = 16'(i);
            tick();
        end
        drive(0, 0, 16'h0, 1, 0);
        tick();
        chk_a("wrap.drained", 1'b0, 16'h0);
        chk("wrap.max", 32'(countA), 32'h0000FFFF);
        drive(1, 0, 16'hBEEF, 1, 0);
        tick();
        drive(0, 0, 16'h0, 1, 0);
        chk_a("wrap.word", 1'b1, 16'hBEEF);
        tick();
        chk("wrap.zero", 32'(countA), 32'd0);
        chk("wrap.countB", 32'(countB), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
